// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid_stage
//  Description : Single-clock valid/ready pipeline stage. SKID=1 provides a
//                head register plus a skid register so in_ready depends only
//                on registered state. SKID=0 provides a single head register
//                with a pass-through ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      SKID    = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] w_skid_data;
  logic             w_in_fire;
  logic             w_out_fire;

  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = head_q;
  assign count      = state_q;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_q;
      logic             w_skid_load;

      // Ready depends on registered state only, breaking the out_ready path.
      assign in_ready = (state_q != ST_TWO);

      // A second entry arrives while the head is stalled.
      assign w_skid_load = ~flush & (state_q == ST_ONE) & w_in_fire & ~w_out_fire;

      // Skid register: captures the overflow entry and holds it otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_q <= RST_VAL;
        end else if (w_skid_load) begin
          skid_q <= in_data;
        end
      end

      assign w_skid_data = skid_q;
    end else begin : g_no_skid
      // Single entry: accept only when empty or when the head drains this cycle.
      assign in_ready    = (state_q == ST_EMPTY) | out_ready;
      assign w_skid_data = RST_VAL;
    end
  endgenerate

  // Occupancy FSM and head register; reset beats flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= RST_VAL;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      head_q  <= RST_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (w_in_fire) begin
            head_q  <= in_data;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            head_q <= in_data;
          end else if (w_in_fire && (SKID != 0)) begin
            state_q <= ST_TWO;
          end else if (w_out_fire) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            head_q  <= w_skid_data;
            state_q <= ST_ONE;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter WIDTH, default 32: payload bit width; legal range 1 to 1024.
REQ-002 Parameter SKID, default 1: 1 selects a 2-entry skid stage; 0 selects a 1-entry pass-through stage.
REQ-003 Parameter RST_VAL, default '0: WIDTH-bit value driven on out_data after reset and after flush.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port flush, input, 1: synchronous squash of all held entries.
REQ-007 Port in_valid, input, 1: upstream offers in_data.
REQ-008 Port in_ready, output, 1: stage accepts in_data this cycle.
REQ-009 Port in_data, input, WIDTH: upstream payload.
REQ-010 Port out_valid, output, 1: out_data holds a valid entry.
REQ-011 Port out_ready, input, 1: downstream consumes the entry this cycle.
REQ-012 Port out_data, output, WIDTH: head entry payload.
REQ-013 Port count, output, 2: number of held entries (0 to 2).

Function
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; both are evaluated in the same cycle.
REQ-015 Storage SHALL be a head register and a skid register (the skid register exists only when SKID=1); out_data SHALL always equal the head register.
REQ-016 State SHALL be one of EMPTY (count 0), ONE (count 1) or TWO (count 2); out_valid = (state != EMPTY).
REQ-017 From EMPTY, in_fire SHALL load the head with in_data and go to ONE; otherwise the stage stays in EMPTY.
REQ-018 From ONE, in_fire with out_fire SHALL load the head with in_data and stay in ONE.
REQ-019 From ONE, in_fire without out_fire SHALL load the skid register and go to TWO (SKID=1 only).
REQ-020 From ONE, out_fire without in_fire SHALL go to EMPTY.
REQ-021 From TWO, in_ready is 0; out_fire SHALL move the skid register into the head and go to ONE.
REQ-022 When SKID=1, in_ready = (state != TWO), a function of registered state only, with no combinational path from out_ready.
REQ-023 When SKID=0, in_ready = (state == EMPTY) | out_ready; state TWO is unreachable and count never exceeds 1.
REQ-024 Latency: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N (1 cycle); ordering SHALL be strict FIFO.
REQ-025 A register that is not loaded SHALL hold its value; out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL force state EMPTY and head to RST_VAL at the next edge.
REQ-027 flush has priority over in_fire and out_fire in the same cycle: incoming data is dropped; out_fire is still reported to downstream that cycle.
REQ-028 in_valid is ignored when in_ready=0; no payload SHALL be lost or duplicated outside of flush.

Reset
REQ-029 rst=1 at an edge SHALL set state EMPTY, count 0, out_valid 0, head RST_VAL and skid RST_VAL; in_ready reads 1 during and after reset.
REQ-030 rst SHALL take priority over flush and all handshakes, including mid-transfer in state TWO.

Verification
REQ-031 Streaming (SKID=1, WIDTH=32): in_valid=1 and out_ready=1 for 8 cycles with data 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles, count stays 1, in_ready stays 1.
REQ-032 Backpressure: load 0xA then 0xB with out_ready=0 -> count=2 and in_ready=0; raise out_ready -> 0xA, then 0xB, then out_valid=0.
REQ-033 Flush in TWO while in_valid=1 with 0xC -> next cycle count=0, out_valid=0, out_data=RST_VAL; 0xC never appears at the output.
REQ-034 SKID=0: out_ready=0 with count=1 -> in_ready=0; out_ready=1 with in_valid=1 -> head replaced in the same edge and count stays 1.
REQ-035 Reset asserted in TWO holding 0x5/0x6 -> after the edge count=0, out_valid=0 and out_data=RST_VAL; 0x5 and 0x6 never appear at the output.
REQ-036 Random valid/ready toggling for at least 10k cycles against a reference queue model -> zero ordering or data mismatches, and count never exceeds 1+SKID.
